// File: rtl/gray_input_decoder.sv
// Debounced Gray-code switch decoder: 2-flop sync, STABLE/SETTLE debounce FSM, registered gray->binary.
// Latency: input change held before edge 1 commits on edge DEBOUNCE_CYCLES+2; no backpressure (free-running).
// Optional GRAY_SEQ_CHECK_EN adds seqError/errorCount for commits that jump more than one Gray step.
module gray_input_decoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] grayIn,
    output logic [3:0] binNumber,
    output logic [3:0] grayStable,
    output logic       newValue,
    output logic       settling
`ifdef GRAY_SEQ_CHECK_EN
    ,
    output logic       seqError,
    output logic [7:0] errorCount
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t          state;
    logic [3:0]      ff1;
    logic [3:0]      syncGray;
    logic [3:0]      candidate;
    logic [CW-1:0]   count;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

`ifdef GRAY_SEQ_CHECK_EN
    // More than one bit set in the difference means the switches skipped a Gray step.
    logic [3:0] diff;
    logic       multi_bit;
    assign diff      = candidate ^ grayStable;
    assign multi_bit = |(diff & (diff - 4'd1));
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ff1        <= 4'b0000;
            syncGray   <= 4'b0000;
            candidate  <= 4'b0000;
            grayStable <= 4'b0000;
            binNumber  <= 4'b0000;
            count      <= '0;
            state      <= STABLE;
            newValue   <= 1'b0;
            settling   <= 1'b0;
`ifdef GRAY_SEQ_CHECK_EN
            seqError   <= 1'b0;
            errorCount <= 8'd0;
`endif
        end else begin
            ff1      <= grayIn;
            syncGray <= ff1;
            newValue <= 1'b0;
            case (state)
                STABLE: begin
                    if (syncGray != grayStable) begin
                        candidate <= syncGray;
                        count     <= CW'(1);
                        state     <= SETTLE;
                        settling  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (syncGray == grayStable) begin
                        count    <= '0;
                        state    <= STABLE;
                        settling <= 1'b0;
                    end else if (syncGray != candidate) begin
                        candidate <= syncGray;
                        count     <= CW'(1);
                    end else if (count == LAST) begin
                        grayStable <= candidate;
                        binNumber  <= gray2bin(candidate);
                        newValue   <= 1'b1;
                        count      <= '0;
                        state      <= STABLE;
                        settling   <= 1'b0;
`ifdef GRAY_SEQ_CHECK_EN
                        if (multi_bit) begin
                            seqError <= 1'b1;
                            if (errorCount != 8'hFF)
                                errorCount <= errorCount + 8'd1;
                        end
`endif
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state    <= STABLE;
                    settling <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_input_decoder.sv
// Bench for gray_input_decoder: run-length debounce model, directed literal scenarios, randomized bounce/reset stimulus.
module tb_gray_input_decoder;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] grayIn = 4'b0000;
    logic [3:0] binNumber;
    logic [3:0] grayStable;
    logic       newValue;
    logic       settling;
`ifdef GRAY_SEQ_CHECK_EN
    logic       seqError;
    logic [7:0] errorCount;
`endif

    int vectors = 0;
    int miscompares = 0;

    gray_input_decoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .grayIn     (grayIn),
        .binNumber  (binNumber),
        .grayStable (grayStable),
        .newValue   (newValue),
        .settling   (settling)
`ifdef GRAY_SEQ_CHECK_EN
        ,
        .seqError   (seqError),
        .errorCount (errorCount)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Binary bit i is the parity of Gray bits i..3.
    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    // Reference: the FSM sees the raw input from two edges earlier; a value commits
    // once it has been seen on D consecutive edges and differs from the committed one.
    logic [3:0] rawq[$];
    logic [3:0] run_val = 4'd0;
    int         run_len = 0;
    logic [3:0] m_stable = 4'd0;
    logic [3:0] m_obs = 4'd0;
    bit         m_commit = 1'b0;
    bit         m_nv = 1'b0;
    bit         m_settle = 1'b0;
    bit         m_err = 1'b0;
    int         m_cnt = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rawq.delete();
            run_val  = 4'd0;
            run_len  = 0;
            m_stable = 4'd0;
            m_nv     = 1'b0;
            m_settle = 1'b0;
            m_err    = 1'b0;
            m_cnt    = 0;
        end else begin
            rawq.push_back(grayIn);
            m_obs = (rawq.size() >= 3) ? rawq[rawq.size() - 3] : 4'd0;
            if (rawq.size() > 3) void'(rawq.pop_front());
            if (m_obs == run_val) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_val = m_obs;
                run_len = 1;
            end
            m_commit = (run_len >= D) && (m_obs != m_stable);
            if (m_commit) begin
                if ($countones(m_obs ^ m_stable) > 1) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                m_stable = m_obs;
            end
            m_nv     = m_commit;
            m_settle = (m_obs != m_stable);
        end
    end

    always @(negedge clock) begin
        chk("model_binNumber", int'(binNumber), int'(g2b(m_stable)));
        chk("model_grayStable", int'(grayStable), int'(m_stable));
        chk("model_newValue", int'(newValue), int'(m_nv));
        chk("model_settling", int'(settling), int'(m_settle));
`ifdef GRAY_SEQ_CHECK_EN
        chk("model_seqError", int'(seqError), int'(m_err));
        chk("model_errorCount", int'(errorCount), m_cnt);
`endif
    end

    task automatic do_reset(input logic [3:0] g);
        grayIn  = g;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(12);
    endtask

    initial begin
        int r;
        int hold;

        // Reset with 0101 on the switches: all zero in reset, commit 0110 on edge 6.
        grayIn  = 4'b0101;
        reset_n = 1'b0;
        step(3);
        chk("rst_bin", int'(binNumber), 0);
        chk("rst_gray", int'(grayStable), 0);
        chk("rst_nv", int'(newValue), 0);
        chk("rst_settling", int'(settling), 0);
        reset_n = 1'b1;
        step(5);
        chk("rel_bin_e5", int'(binNumber), 0);
        chk("rel_nv_e5", int'(newValue), 0);
        step(1);
        chk("rel_bin_e6", int'(binNumber), 6);
        chk("rel_gray_e6", int'(grayStable), 5);
        chk("rel_nv_e6", int'(newValue), 1);
        step(1);
        chk("rel_nv_e7", int'(newValue), 0);

        // 0000 -> 0001 held.
        do_reset(4'b0000);
        grayIn = 4'b0001;
        step(2);
        chk("s1_settling_e2", int'(settling), 0);
        step(1);
        chk("s1_settling_e3", int'(settling), 1);
        step(2);
        chk("s1_settling_e5", int'(settling), 1);
        chk("s1_bin_e5", int'(binNumber), 0);
        step(1);
        chk("s1_bin_e6", int'(binNumber), 1);
        chk("s1_gray_e6", int'(grayStable), 1);
        chk("s1_nv_e6", int'(newValue), 1);
        chk("s1_settling_e6", int'(settling), 0);
        step(1);
        chk("s1_nv_e7", int'(newValue), 0);

        // Two-cycle glitch is rejected.
        do_reset(4'b0000);
        grayIn = 4'b0001;
        step(2);
        grayIn = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("glitch_nv", int'(newValue), 0);
            chk("glitch_bin", int'(binNumber), 0);
        end
        chk("glitch_settling", int'(settling), 0);

        // Bounce 0011 -> 0010: only the final value commits.
        do_reset(4'b0000);
        grayIn = 4'b0011;
        step(2);
        grayIn = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("bounce_gray_pre", int'(grayStable), 0);
        end
        step(1);
        chk("bounce_bin", int'(binNumber), 3);
        chk("bounce_gray", int'(grayStable), 2);

        // Reset mid-settle discards the candidate, then full latency again.
        do_reset(4'b0000);
        grayIn = 4'b0110;
        step(4);
        chk("midrst_settling_pre", int'(settling), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_bin", int'(binNumber), 0);
        chk("midrst_gray", int'(grayStable), 0);
        chk("midrst_settling", int'(settling), 0);
        chk("midrst_nv", int'(newValue), 0);
        step(2);
        reset_n = 1'b1;
        step(5);
        chk("midrst_bin_e5", int'(binNumber), 0);
        step(1);
        chk("midrst_bin_e6", int'(binNumber), 4);
        chk("midrst_nv_e6", int'(newValue), 1);

`ifdef GRAY_SEQ_CHECK_EN
        do_reset(4'b0000);
        grayIn = 4'b0110;
        step(7);
        chk("seq_err_jump", int'(seqError), 1);
        chk("seq_cnt_jump", int'(errorCount), 1);
        grayIn = 4'b0111;
        step(7);
        chk("seq_gray_step", int'(grayStable), 7);
        chk("seq_cnt_step", int'(errorCount), 1);
`endif

        // Randomized bouncing, holds around the D boundary, occasional resets.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                reset_n = 1'b0;
                step($urandom_range(1, 3));
                reset_n = 1'b1;
            end else begin
                if (r < 12)
                    grayIn = grayIn ^ (4'b0001 << $urandom_range(0, 3));
                else
                    grayIn = 4'($urandom_range(0, 15));
                hold = (r < 10) ? $urandom_range(1, D + 1) : $urandom_range(D + 2, 12);
                step(hold);
            end
        end
        step(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
